// File: rtl/stage2_operand_feeder.sv
// stage2_operand_feeder
//   Transmit side of the stage-2 operand stream. Reads per-beat operand/scale
//   vectors from a 1-cycle-latency SRAM into a 2-entry skid FIFO and presents
//   them, with lane position indices, to the stage-2 datapath. stall_o is
//   driven so the consumer's step counter advances only on beats carrying
//   valid data. The run covers beats 0..stage_boundary[6]+1.
//
//   Ports:
//     CLK_i, RST_i             clock, async active-high reset
//     start_i                  run start pulse (ignored unless idle)
//     stage_boundary           boundary set, [6] sets the run length
//     dn_hold_i                consumer backpressure
//     rd_en_o, rd_addr_o       SRAM read request
//     rd_operand_i, rd_scale_i SRAM read data (1 cycle after rd_en_o)
//     operand_o, scale_o       FIFO head to consumer
//     pos_o                    lane positions step*PARALLEL+i
//     stall_o, busy_o, done_o  consumer stall, run active, run-end pulse
//     perf_stall_cnt_o         only with STAGE2_FEEDER_PERF_EN: saturating
//                              count of busy&&stall cycles
module stage2_operand_feeder #(
  parameter int WIDTH    = 16,
  parameter int PARALLEL = 2,
  parameter int STEP_W   = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                            CLK_i,
  input  logic                            RST_i,
  input  logic                            start_i,
  input  logic [6:0][STEP_W-1:0]          stage_boundary,
  input  logic                            dn_hold_i,
  output logic                            rd_en_o,
  output logic [ADDR_W-1:0]               rd_addr_o,
  input  logic [PARALLEL-1:0][WIDTH-1:0]  rd_operand_i,
  input  logic [PARALLEL-1:0][WIDTH-1:0]  rd_scale_i,
  output logic [PARALLEL-1:0][WIDTH-1:0]  operand_o,
  output logic [PARALLEL-1:0][WIDTH-1:0]  scale_o,
  output logic [PARALLEL-1:0][WIDTH-1:0]  pos_o,
  output logic                            stall_o,
  output logic                            busy_o,
  output logic                            done_o
`ifdef STAGE2_FEEDER_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [STEP_W:0] last_q, issue_q, step_q, total;
  logic [1:0][PARALLEL-1:0][WIDTH-1:0] mem_op, mem_sc;
  logic       wr_ptr, rd_ptr, inflight;
  logic [1:0] cnt;
  logic       empty, push, pop, active, start_ok;
  logic [2:0] occ_after;

  // Boundaries 0..5 only matter to the consumer's stage decode.
  logic unused_bnd;
  assign unused_bnd = ^stage_boundary[5:0];

  assign total    = last_q + (STEP_W+1)'(2);
  assign empty    = (cnt == 2'd0);
  assign active   = (state == FILL) || (state == STREAM);
  assign start_ok = (state == IDLE) && start_i;
  assign push     = inflight;
  assign pop      = (state == STREAM) && !empty && !dn_hold_i;

  // Occupancy counts the beat leaving this cycle, so a full pipe can
  // re-issue while popping and sustain one beat per cycle.
  assign occ_after = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};

  assign rd_en_o   = active && (occ_after < 3'd2) && (issue_q < total);
  assign rd_addr_o = ADDR_W'(issue_q);

  assign operand_o = mem_op[rd_ptr];
  assign scale_o   = mem_sc[rd_ptr];
  assign busy_o    = active;
  assign done_o    = (state == DONE);
  assign stall_o   = (state != STREAM) || empty || dn_hold_i;

  // Positions forced to 0 outside a run so idle outputs are all-zero.
  for (genvar g = 0; g < PARALLEL; g++) begin : g_pos
    assign pos_o[g] = busy_o ? WIDTH'(int'(step_q) * PARALLEL + g) : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = FILL;
      FILL:    if (push) state_nxt = STREAM;
      STREAM:  if (pop && (step_q == total - (STEP_W+1)'(1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state    <= IDLE;
      last_q   <= '0;
      issue_q  <= '0;
      step_q   <= '0;
      mem_op   <= '0;
      mem_sc   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en_o;
      if (start_ok) begin
        last_q  <= {1'b0, stage_boundary[6]};
        issue_q <= '0;
        step_q  <= '0;
      end else begin
        if (rd_en_o) issue_q <= issue_q + (STEP_W+1)'(1);
        if (pop)     step_q  <= step_q + (STEP_W+1)'(1);
      end
      if (push) begin
        mem_op[wr_ptr] <= rd_operand_i;
        mem_sc[wr_ptr] <= rd_scale_i;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

`ifdef STAGE2_FEEDER_PERF_EN
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i)                                              perf_stall_cnt_o <= '0;
    else if (start_ok)                                      perf_stall_cnt_o <= '0;
    else if (busy_o && stall_o && (perf_stall_cnt_o != '1)) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stage2_operand_feeder.sv
// Scoreboard bench for stage2_operand_feeder (ADDR_W=2 to exercise address wrap).
module tb_stage2_operand_feeder;
  localparam int W = 16, P = 2, SW = 8, AW = 2;

  typedef struct {
    logic [P-1:0][W-1:0] op;
    logic [P-1:0][W-1:0] sc;
    logic [P-1:0][W-1:0] pos;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic [6:0][SW-1:0] bnd;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [P-1:0][W-1:0] rd_op, rd_sc, op, sc, pos;
  logic stall, busy, done;
`ifdef STAGE2_FEEDER_PERF_EN
  logic [31:0] perf;
`endif

  beat_t expq[$];
  beat_t e;
  int addrlog[$];
  int passed = 0, total = 0, beats_seen = 0;

  always #5 clk = ~clk;

  stage2_operand_feeder #(.WIDTH(W), .PARALLEL(P), .STEP_W(SW), .ADDR_W(AW)) u_dut (
    .CLK_i(clk), .RST_i(rst), .start_i(start), .stage_boundary(bnd), .dn_hold_i(hold),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_operand_i(rd_op), .rd_scale_i(rd_sc),
    .operand_o(op), .scale_o(sc), .pos_o(pos), .stall_o(stall), .busy_o(busy), .done_o(done)
`ifdef STAGE2_FEEDER_PERF_EN
    , .perf_stall_cnt_o(perf)
`endif
  );

  function automatic logic [P-1:0][W-1:0] mk(input logic [W-1:0] base, input int a);
    logic [P-1:0][W-1:0] v;
    for (int i = 0; i < P; i++) v[i] = base + W'(a * 16 + i);
    return v;
  endfunction

  // 1-cycle-latency SRAM model
  always @(posedge clk) if (rd_en) begin
    rd_op <= mk(16'h1000, int'(rd_addr));
    rd_sc <= mk(16'h2000, int'(rd_addr));
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: a beat is consumed on each edge where stall_o is low.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) addrlog.push_back(int'(rd_addr));
      if (!stall) begin
        if (expq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = expq.pop_front();
          chk("beat_op", op, e.op);
          chk("beat_sc", sc, e.sc);
          chk("beat_pos", pos, e.pos);
        end
        beats_seen++;
      end
    end
  end

  task automatic push_exp(input int L);
    for (int k = 0; k < L + 2; k++) begin
      beat_t b;
      b.op  = mk(16'h1000, k % 4);
      b.sc  = mk(16'h2000, k % 4);
      b.pos = {W'(2 * k + 1), W'(2 * k)};
      expq.push_back(b);
    end
  endtask

  task automatic pulse_start(input int L);
    for (int k = 0; k < 6; k++) bnd[k] = SW'(k + 1);
    bnd[6] = SW'(L);
    beats_seen = 0;
    addrlog.delete();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run(input int L, input int hold_at, input int hold_len);
    int held = 0, dones = 0, fin_cyc = -1, gaps = 0, bad = 0;
    push_exp(L);
    pulse_start(L);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(posedge clk); #2;
      if (hold_at >= 0 && beats_seen == hold_at && held < hold_len) begin
        hold = 1'b1;
        held++;
      end else hold = 1'b0;
      #1;
      if (hold) begin
        chk("hold_pos", pos, {W'(2 * hold_at + 1), W'(2 * hold_at)});
        chk("hold_op", op, mk(16'h1000, hold_at % 4));
        chk("hold_stall", stall, 1);
      end
      if (cyc == 1) chk("stall_fill", stall, 1);
      if (cyc == 2) chk("stall_fall_start+2", stall, 0);
      if (busy && stall && !hold && cyc >= 2) gaps++;
      if (done) begin
        dones++;
        chk("busy_low_at_done", busy, 0);
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      if (fin_cyc >= 0 && cyc >= fin_cyc + 3) break;
    end
    hold = 1'b0;
    chk("done_count", dones, 1);
    chk("beat_count", beats_seen, L + 2);
    chk("queue_drained", expq.size(), 0);
    chk("stream_gaps", gaps, 0);
    chk("addr_count", addrlog.size(), L + 2);
    foreach (addrlog[i]) if (addrlog[i] != i % 4) bad++;
    chk("addr_seq", bad, 0);
    expq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stall"}, stall, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_op"}, op, 0);
    chk({tag, "_sc"}, sc, 0);
    chk({tag, "_pos"}, pos, 0);
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; hold = 1'b0; bnd = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst = 1'b0;

    run(5, -1, 0);   // plain run, 7 beats
    run(5, 3, 3);    // hold at beat 3 for 3 cycles
    run(0, -1, 0);   // degenerate: 2 beats
    run(6, -1, 0);   // 8 beats, address wraps 0..3,0..3

    // Reset at beat 4: outputs return asynchronously, no done_o
    push_exp(5);
    pulse_start(5);
    waited = 0;
    while (beats_seen != 4 && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("reach_beat4", beats_seen, 4);
    rst = 1'b1;
    #1 chk_reset_vals("midrun_reset");
    repeat (3) @(negedge clk) chk("no_done_in_reset", done, 0);
    expq.delete();
    rst = 1'b0;
    run(2, -1, 0);   // clean run after abort

`ifdef STAGE2_FEEDER_PERF_EN
    run(3, 1, 4);
    chk("perf_stall_cnt", perf, 6);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stage2_operand_feeder.md
Name: stage2_operand_feeder

Overview:
- Transmit side of the stage-2 operand stream: reads per-beat operand/scale vectors from a 1-cycle-latency SRAM and presents them, with position indices, to the stage-2 datapath.
- Drives the datapath's stall input so that its step counter advances only on beats carrying valid data.
- Mirrors the consumer's step count against the same stage_boundary set, so both ends agree on when the run finishes.

Parameters:
- WIDTH, 16, element width (fp16 bit pattern, passed through untouched)
- PARALLEL, 2, lanes per beat
- STEP_W, 8, step counter / boundary width
- ADDR_W, 12, SRAM beat-address width

Ports:
- CLK_i  in  1  clock
- RST_i  in  1  asynchronous reset, active-high
- start_i  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
- stage_boundary  in  [6:0][STEP_W-1:0]  same boundary set as consumer; sampled at start
- dn_hold_i  in  1  consumer-side backpressure; beat is not consumed while high
- rd_en_o  out  1  SRAM read strobe
- rd_addr_o  out  ADDR_W  SRAM beat address
- rd_operand_i  in  [PARALLEL-1:0][WIDTH-1:0]  SRAM operand data, valid 1 cycle after rd_en_o
- rd_scale_i  in  [PARALLEL-1:0][WIDTH-1:0]  SRAM scale data, same timing
- operand_o  out  [PARALLEL-1:0][WIDTH-1:0]  to consumer operand_i
- scale_o  out  [PARALLEL-1:0][WIDTH-1:0]  to consumer scale_i
- pos_o  out  [PARALLEL-1:0][WIDTH-1:0]  to consumer pos
- stall_o  out  1  to consumer stall_i
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end

Behaviour:
- Reset values: all data outputs 0, rd_en_o=0, rd_addr_o=0, stall_o=1, busy_o=0, done_o=0. FSM returns to IDLE; skid buffer is emptied.
- Run length: last = stage_boundary[6] latched at start, zero-extended to STEP_W+1. The run has beats 0..last+1, i.e. last+2 beats, so the consumer's step ends strictly greater than boundary[6] (stage 7).
- FSM states:
  - IDLE: stall_o=1. On start_i, latch boundaries, clear counters, go to FILL.
  - FILL: issue reads for addresses 0 and 1 on consecutive cycles. Go to STREAM when the first data lands.
  - STREAM: present beats to the consumer. After the final beat is consumed, go to DONE.
  - DONE: pulse done_o for one cycle, go to IDLE.
- Skid buffer: 2-entry FIFO absorbs the 1-cycle read latency.
  - Issue rule: rd_en_o=1 iff (entries + reads in flight) < 2 and issue count < last+2.
  - rd_addr_o = issue count modulo 2^ADDR_W (wraps silently).
- Beat consumption: a beat is consumed in a cycle where the FIFO is non-empty and dn_hold_i=0.
  - stall_o = FIFO empty OR dn_hold_i.
  - operand_o and scale_o show the FIFO head combinationally.
  - Only the count of consumed beats (step) advances the run.
- Position: pos_o[i] = step*PARALLEL + i, truncated to WIDTH. Held constant while stalled.
- Simultaneous events:
  - Push and pop in the same cycle leave the FIFO occupancy unchanged.
  - start_i while busy is ignored.
  - dn_hold_i during FILL or DONE has no effect beyond stall_o.
- Reset mid-run: aborts immediately; no done_o. In-flight SRAM data returned after reset is discarded.
- Latency: start_i to first unstalled beat = 2 cycles (stall_o falls in cycle start+2) when dn_hold_i=0. Steady-state throughput is 1 beat/cycle.
- Degenerate case: stage_boundary[6]=0 gives exactly 2 beats.

Optional Feature:
- Macro STAGE2_FEEDER_PERF_EN.
- Defined: adds output perf_stall_cnt_o, 32 bits, counting cycles with busy_o=1 and stall_o=1. Saturates at all-ones; cleared on start_i and on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start_i with boundary[6]=5, dn_hold_i=0:
  - stall_o falls at cycle start+2.
  - 7 consecutive beats carry pos_o lane0 = 0,2,4,...,12.
  - done_o pulses exactly once, and busy_o falls in the same cycle.
- Same run with dn_hold_i high for 3 cycles at beat 3:
  - operand_o and pos_o (6,7) hold during the hold window.
  - The FIFO never exceeds 2 entries and no beat is lost or duplicated.
  - Total 7 beats.
- boundary[6]=0: exactly 2 beats (pos 0 and 2), then done_o.
- Assert RST_i mid-run at beat 4: all outputs return to reset values asynchronously, with no done_o. A new start gives a clean run from pos 0.
- Start with last+2 > 2^ADDR_W (ADDR_W=2, boundary[6]=6): rd_addr_o sequence is 0,1,2,3,0,1,2,3.
- With PERF_EN: hold dn_hold_i for 4 cycles in a boundary[6]=3 run → perf_stall_cnt_o = 4 + 2 fill cycles = 6.
